// File: rtl/axi_lite_read_responder_if.sv
// AXI-Lite read-channel bundle (AR + R) shared by the read responder and its master.
// The master drives the address and rready; the slave drives arready and the R beat.
interface axi_lite_read_responder_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_read_responder.sv
// AXI-Lite slave read engine: one outstanding AR, word-indexed req/ack register read, held R beat.
// Optional WAIT timeout with SLVERR is enabled by defining AXIL_RD_TIMEOUT_EN.
module axi_lite_read_responder #(
    parameter int unsigned AXI_ADDR_WIDTH  = 12,
    parameter int unsigned AXI_RDATA_WIDTH = 32,
    parameter int unsigned NUM_REGS        = 64,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    axi_lite_read_responder_if.slave    axi,
    output logic                        reg_rd_req,
    output logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
    input  logic                        reg_rd_ack,
    input  logic [AXI_RDATA_WIDTH-1:0]  reg_rd_data
);
    localparam int unsigned RA_W  = $clog2(NUM_REGS);
    localparam int unsigned IDX_W = AXI_ADDR_WIDTH - 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]                 state;
    logic                       rvalid_q;
    logic [AXI_RDATA_WIDTH-1:0] rdata_q;
    logic [1:0]                 rresp_q;
    logic [IDX_W-1:0]           idx;
    logic                       bad_addr;
    logic                       ar_fire;
    logic                       to_fire;

    // The whole upper address is compared, so out-of-range high bits never alias into the map
    assign idx      = axi.araddr[AXI_ADDR_WIDTH-1:2];
    assign bad_addr = (axi.araddr[1:0] != 2'b00) || (32'(idx) >= NUM_REGS);

    assign axi.arready = (state == S_IDLE) & ~reset;
    assign ar_fire     = axi.arvalid & axi.arready;

    assign axi.rvalid = rvalid_q;
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = rresp_q;

    logic unused_prot;
    assign unused_prot = ^axi.arprot;

`ifdef AXIL_RD_TIMEOUT_EN
    localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);

    logic [CW-1:0] wait_cnt;

    // An ack in the same cycle as the limit takes priority, so the timeout is gated by ~ack
    assign to_fire = (state == S_WAIT) & ~reg_rd_ack &
                     ((32'(wait_cnt) + 32'd1) >= TIMEOUT_CYCLES);

    // Count WAIT cycles that pass without an ack; cleared whenever a new WAIT begins
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (ar_fire) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT && !reg_rd_ack) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end
`else
    assign to_fire = 1'b0;

    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES[0];
`endif

    // Transaction FSM: accept AR, issue the one-cycle strobe, capture data, hold the R beat
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            reg_rd_req  <= 1'b0;
            reg_rd_addr <= '0;
        end else begin
            reg_rd_req <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ar_fire) begin
                        if (bad_addr) begin
                            state    <= S_RESP;
                            rvalid_q <= 1'b1;
                            rresp_q  <= RESP_SLVERR;
                            rdata_q  <= '0;
                        end else begin
                            state       <= S_WAIT;
                            reg_rd_req  <= 1'b1;
                            reg_rd_addr <= idx[RA_W-1:0];
                        end
                    end
                end
                S_WAIT: begin
                    if (reg_rd_ack) begin
                        state    <= S_RESP;
                        rvalid_q <= 1'b1;
                        rresp_q  <= RESP_OKAY;
                        rdata_q  <= reg_rd_data;
                    end else if (to_fire) begin
                        state    <= S_RESP;
                        rvalid_q <= 1'b1;
                        rresp_q  <= RESP_SLVERR;
                        rdata_q  <= '0;
                    end
                end
                S_RESP: begin
                    if (rvalid_q && axi.rready) begin
                        state    <= S_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_read_responder.sv
// Directed table-driven bench for axi_lite_read_responder.
// Timeout vectors are included when AXIL_RD_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_axi_lite_read_responder;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NR = 64;
    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reg_rd_req;
    logic [5:0]  reg_rd_addr;
    logic        reg_rd_ack = 1'b0;
    logic [31:0] reg_rd_data = 32'h0;

    axi_lite_read_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_lite_read_responder #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_RDATA_WIDTH(DW),
        .NUM_REGS       (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .axi        (axi),
        .reg_rd_req (reg_rd_req),
        .reg_rd_addr(reg_rd_addr),
        .reg_rd_ack (reg_rd_ack),
        .reg_rd_data(reg_rd_data)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [11:0] addr;
        int          ack_dly;
        logic [31:0] data;
        int          hold;
        bit          b2b;
        bit          err;
        int          lat;
        logic [5:0]  idx;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the R handshake
    task automatic do_read(input vec_t v, input string tag);
        int          rq_cyc = 0;
        int          rv_cyc = 0;
        int          nreq = 0;
        bit          done = 0;
        bit          ar_bad = 0;
        bit          unstable = 0;
        logic [31:0] d0 = 32'h0;
        logic [1:0]  r0 = 2'b0;
        logic [5:0]  a0 = 6'h0;
        chk({tag, "_arready"}, 32'(axi.arready), 32'd1);
        axi.araddr  = v.addr;
        axi.arvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (v.b2b) axi.araddr = 12'h020;
        else axi.arvalid = 1'b0;
        for (int c = 1; c <= 400 && !done; c++) begin
            if (axi.arready) ar_bad = 1;
            if (reg_rd_req) begin
                nreq++;
                rq_cyc = c;
                a0 = reg_rd_addr;
            end
            reg_rd_ack  = (rq_cyc != 0 && c == rq_cyc + v.ack_dly && rv_cyc == 0);
            reg_rd_data = reg_rd_ack ? v.data : 32'hDEAD_BEEF;
            if (axi.rvalid) begin
                if (rv_cyc == 0) begin
                    rv_cyc = c;
                    d0 = axi.rdata;
                    r0 = axi.rresp;
                end else if (axi.rdata !== d0 || axi.rresp !== r0) begin
                    unstable = 1;
                end
                if (v.hold > 0) begin
                    reg_rd_ack  = 1'b1;
                    reg_rd_data = 32'h0BAD_0BAD;
                end
                axi.rready = (c >= rv_cyc + v.hold);
                done = axi.rready;
            end else begin
                axi.rready = 1'b0;
            end
            @(posedge clock);
            @(negedge clock);
        end
        reg_rd_ack = 1'b0;
        axi.rready = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(rv_cyc), 32'(v.lat));
        chk({tag, "_nreq"}, 32'(nreq), v.err ? 32'd0 : 32'd1);
        if (!v.err) chk({tag, "_idx"}, 32'(a0), 32'(v.idx));
        chk({tag, "_rresp"}, 32'(r0), v.err ? 32'd2 : 32'd0);
        chk({tag, "_rdata"}, d0, v.err ? 32'd0 : v.data);
        chk({tag, "_stable"}, 32'(unstable), 32'd0);
        chk({tag, "_arready_busy"}, 32'(ar_bad), 32'd0);
        chk({tag, "_rvalid_drop"}, 32'(axi.rvalid), 32'd0);
        if (v.b2b) begin
            chk({tag, "_arready_after"}, 32'(axi.arready), 32'd1);
            axi.arvalid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs.push_back('{12'h010, 0, 32'hCAFE_0001, 0, 1'b0, 1'b0, 2, 6'd4});
        vecs.push_back('{12'h013, 0, 32'h1111_1111, 0, 1'b0, 1'b1, 1, 6'd0});
        vecs.push_back('{12'h100, 0, 32'h2222_2222, 0, 1'b0, 1'b1, 1, 6'd0});
        vecs.push_back('{12'h0FC, 3, 32'h1234_5678, 2, 1'b0, 1'b0, 5, 6'd63});
        vecs.push_back('{12'h800, 0, 32'h3333_3333, 0, 1'b0, 1'b1, 1, 6'd0});
        vecs.push_back('{12'h002, 0, 32'h4444_4444, 1, 1'b0, 1'b1, 1, 6'd0});
        vecs.push_back('{12'h000, 1, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 3, 6'd0});
        vecs.push_back('{12'h044, 0, 32'hA5A5_0044, 10, 1'b1, 1'b0, 2, 6'd17});
`ifdef AXIL_RD_TIMEOUT_EN
        vecs.push_back('{12'h008, 1000, 32'h5555_5555, 0, 1'b0, 1'b1, 9, 6'd2});
        vecs.push_back('{12'h00C, 7, 32'h55AA_55AA, 0, 1'b0, 1'b0, 9, 6'd3});
        vecs.push_back('{12'h018, 6, 32'h66AA_66AA, 0, 1'b0, 1'b0, 8, 6'd6});
`else
        vecs.push_back('{12'h018, 20, 32'h66AA_66AA, 0, 1'b0, 1'b0, 22, 6'd6});
`endif

        axi.araddr  = '0;
        axi.arprot  = 3'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;

        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_arready", 32'(axi.arready), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_arready", 32'(axi.arready), 32'd1);
        chk("post_reset_rvalid", 32'(axi.rvalid), 32'd0);
        chk("post_reset_rdata", axi.rdata, 32'd0);
        chk("post_reset_rresp", 32'(axi.rresp), 32'd0);
        chk("post_reset_req", 32'(reg_rd_req), 32'd0);
        chk("post_reset_addr", 32'(reg_rd_addr), 32'd0);

        foreach (vecs[i]) do_read(vecs[i], $sformatf("v%0d", i));

        axi.arprot  = 3'b101;
        axi.araddr  = 12'h030;
        axi.arvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        axi.arvalid = 1'b0;
        chk("rst_wait_req", 32'(reg_rd_req), 32'd1);
        chk("rst_wait_addr", 32'(reg_rd_addr), 32'd12);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rst_wait_arready_low", 32'(axi.arready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        reg_rd_ack  = 1'b1;
        reg_rd_data = 32'h7777_7777;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (axi.rvalid) seen = 1;
            @(posedge clock);
            @(negedge clock);
            reg_rd_ack = 1'b0;
        end
        chk("rst_wait_no_rvalid", 32'(seen), 32'd0);
        chk("rst_wait_arready", 32'(axi.arready), 32'd1);
        chk("rst_wait_rdata", axi.rdata, 32'd0);
        chk("rst_wait_addr_clr", 32'(reg_rd_addr), 32'd0);
        axi.arprot = 3'b000;

        do_read('{12'h0A8, 2, 32'h0F0F_1234, 0, 1'b0, 1'b0, 4, 6'd42}, "recover");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
